operand_fetch_stage: RTL and testbench

- Decode/operand-fetch pipeline stage in front of the register file.
- Extracts rs1/rs2 from the incoming instruction, drives the register-file read addresses, and bypasses a same-cycle writeback.
- Registers instruction, PC and operands into a 2-entry skid buffer feeding EX with valid/ready handshake.
- Held entries snoop later writebacks so buffered operands never go stale.

---
 rtl/rv_pkg.sv | 29 ++
 rtl/opf_operand_mux.sv | 46 ++++
 rtl/operand_fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V decode constants and the operand-fetch entry layout.
// Used by operand_fetch_stage and opf_operand_mux.
package rv_pkg;

   localparam int XLEN    = 32;
   localparam int REG_AW  = 5;
   localparam int ILEN    = 32;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;

   typedef struct packed {
      logic              valid;
      logic [ILEN-1:0]   instr;
      logic [XLEN-1:0]   pc;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [XLEN-1:0]   rs1_val;
      logic [XLEN-1:0]   rs2_val;
   } opf_entry_t;

   function automatic logic [REG_AW-1:0] rs1_of(input logic [ILEN-1:0] instr);
      return instr[RS1_LSB +: REG_AW];
   endfunction

   function automatic logic [REG_AW-1:0] rs2_of(input logic [ILEN-1:0] instr);
      return instr[RS2_LSB +: REG_AW];
   endfunction

endpackage

// File: rtl/opf_operand_mux.sv
// One source operand: x0 / same-cycle writeback bypass / register-file select
// for a new instruction, plus writeback snooping of the head and skid copies.
module opf_operand_mux
   import rv_pkg::*;
#(
   parameter int XLEN   = rv_pkg::XLEN,
   parameter int REG_AW = rv_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] new_addr,
   input  logic [XLEN-1:0]   rf_data,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic [REG_AW-1:0] hd_addr,
   input  logic [XLEN-1:0]   hd_val,
   input  logic [REG_AW-1:0] sk_addr,
   input  logic [XLEN-1:0]   sk_val,
   output logic [XLEN-1:0]   new_val,
   output logic [XLEN-1:0]   hd_val_snp,
   output logic [XLEN-1:0]   sk_val_snp
);

   logic wb_live;

   // A writeback to x0 never changes architectural state, so it never matches.
   assign wb_live = wb_en && (wb_addr != '0);

   function automatic logic wb_hit(input logic [REG_AW-1:0] addr,
                                   input logic              live,
                                   input logic [REG_AW-1:0] waddr);
      return live && (addr == waddr);
   endfunction

   always_comb begin
      new_val = rf_data;
      if (new_addr == '0) begin
         new_val = '0;
      end else if (wb_hit(new_addr, wb_live, wb_addr)) begin
         new_val = wb_data;
      end
   end

   assign hd_val_snp = wb_hit(hd_addr, wb_live, wb_addr) ? wb_data : hd_val;
   assign sk_val_snp = wb_hit(sk_addr, wb_live, wb_addr) ? wb_data : sk_val;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: reg-file addressing, writeback bypass, 2-entry skid buffer to EX.
// Optional upstream stall counter enabled with macro OPF_STALL_CNT_EN.
module operand_fetch_stage
   import rv_pkg::*;
#(
   parameter int XLEN   = rv_pkg::XLEN,
   parameter int REG_AW = rv_pkg::REG_AW,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RES,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic [REG_AW-1:0] RA_RF,
   output logic [REG_AW-1:0] RB_RF,
   input  logic [XLEN-1:0]   A_RF,
   input  logic [XLEN-1:0]   B_RF,
   input  logic              WE_RF,
   input  logic [REG_AW-1:0] RW_RF,
   input  logic [XLEN-1:0]   DW_RF,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_rs1_val,
   output logic [XLEN-1:0]   out_rs2_val,
   output logic [CNT_W-1:0]  stall_cnt
);

   opf_entry_t hd_p1;
   opf_entry_t sk_p1;
   opf_entry_t hd_base;
   opf_entry_t hd_snp;
   opf_entry_t sk_snp;
   opf_entry_t new_ent;

   logic              accept;
   logic              pop;
   logic [XLEN-1:0]   new_rs1_val;
   logic [XLEN-1:0]   new_rs2_val;
   logic [XLEN-1:0]   hd_rs1_snp;
   logic [XLEN-1:0]   hd_rs2_snp;
   logic [XLEN-1:0]   sk_rs1_snp;
   logic [XLEN-1:0]   sk_rs2_snp;

   assign RA_RF = rs1_of(in_instr);
   assign RB_RF = rs2_of(in_instr);

   // Ready depends only on the skid flop, never on out_ready.
   assign in_ready = !sk_p1.valid;
   assign accept   = in_valid && in_ready;
   assign pop      = hd_p1.valid && out_ready;

   // Head after a possible skid->head move; snooping applies to this value.
   assign hd_base = (pop && sk_p1.valid) ? sk_p1 : hd_p1;

   opf_operand_mux #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_mux_rs1 (
      .new_addr   (RA_RF),
      .rf_data    (A_RF),
      .wb_en      (WE_RF),
      .wb_addr    (RW_RF),
      .wb_data    (DW_RF),
      .hd_addr    (hd_base.rs1),
      .hd_val     (hd_base.rs1_val),
      .sk_addr    (sk_p1.rs1),
      .sk_val     (sk_p1.rs1_val),
      .new_val    (new_rs1_val),
      .hd_val_snp (hd_rs1_snp),
      .sk_val_snp (sk_rs1_snp)
   );

   opf_operand_mux #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_mux_rs2 (
      .new_addr   (RB_RF),
      .rf_data    (B_RF),
      .wb_en      (WE_RF),
      .wb_addr    (RW_RF),
      .wb_data    (DW_RF),
      .hd_addr    (hd_base.rs2),
      .hd_val     (hd_base.rs2_val),
      .sk_addr    (sk_p1.rs2),
      .sk_val     (sk_p1.rs2_val),
      .new_val    (new_rs2_val),
      .hd_val_snp (hd_rs2_snp),
      .sk_val_snp (sk_rs2_snp)
   );

   always_comb begin
      hd_snp         = hd_base;
      hd_snp.rs1_val = hd_rs1_snp;
      hd_snp.rs2_val = hd_rs2_snp;

      sk_snp         = sk_p1;
      sk_snp.rs1_val = sk_rs1_snp;
      sk_snp.rs2_val = sk_rs2_snp;

      new_ent.valid   = 1'b1;
      new_ent.instr   = in_instr;
      new_ent.pc      = in_pc;
      new_ent.rs1     = RA_RF;
      new_ent.rs2     = RB_RF;
      new_ent.rs1_val = new_rs1_val;
      new_ent.rs2_val = new_rs2_val;
   end

   // ---- stage p1: head / skid registers ----
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         hd_p1 <= '0;
         sk_p1 <= '0;
      end else if (flush) begin
         hd_p1.valid <= 1'b0;
         sk_p1.valid <= 1'b0;
      end else if (pop && sk_p1.valid) begin
         hd_p1       <= hd_snp;
         sk_p1.valid <= 1'b0;
      end else if (!hd_p1.valid || pop) begin
         if (accept) begin
            hd_p1 <= new_ent;
         end else begin
            hd_p1.valid <= 1'b0;
         end
      end else begin
         hd_p1 <= hd_snp;
         sk_p1 <= accept ? new_ent : sk_snp;
      end
   end

   assign out_valid   = hd_p1.valid;
   assign out_instr   = hd_p1.instr;
   assign out_pc      = hd_p1.pc;
   assign out_rs1_val = hd_p1.rs1_val;
   assign out_rs2_val = hd_p1.rs2_val;

`ifdef OPF_STALL_CNT_EN
   logic [CNT_W-1:0] stall_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // ---- stage p1: upstream stall counter ----
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         stall_p1 <= '0;
      end else if (in_valid && !in_ready) begin
         stall_p1 <= sat_inc(stall_p1);
      end
   end

   assign stall_cnt = stall_p1;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed steps then random traffic against a queue model.
module tb_operand_fetch_stage;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 32;

   logic              CLK = 1'b0;
   logic              RES;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [XLEN-1:0]   in_pc;
   logic              flush;
   logic [REG_AW-1:0] RA_RF;
   logic [REG_AW-1:0] RB_RF;
   logic [XLEN-1:0]   A_RF;
   logic [XLEN-1:0]   B_RF;
   logic              WE_RF;
   logic [REG_AW-1:0] RW_RF;
   logic [XLEN-1:0]   DW_RF;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [XLEN-1:0]   out_pc;
   logic [XLEN-1:0]   out_rs1_val;
   logic [XLEN-1:0]   out_rs2_val;
   logic [CNT_W-1:0]  stall_cnt;

   operand_fetch_stage #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW),
      .CNT_W  (CNT_W)
   ) dut (
      .CLK         (CLK),
      .RES         (RES),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .flush       (flush),
      .RA_RF       (RA_RF),
      .RB_RF       (RB_RF),
      .A_RF        (A_RF),
      .B_RF        (B_RF),
      .WE_RF       (WE_RF),
      .RW_RF       (RW_RF),
      .DW_RF       (DW_RF),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_rs1_val (out_rs1_val),
      .out_rs2_val (out_rs2_val),
      .stall_cnt   (stall_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] v1;
      logic [31:0] v2;
   } ent_t;

   ent_t             q[$];
   logic [CNT_W-1:0] stall_m;
   int               checks   = 0;
   int               failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'h00, rs2, rs1, 3'b000, 5'd1, 7'h33};
   endfunction

   function automatic logic [31:0] opsel(input logic [4:0] a, input logic [31:0] rf);
      if (a == 5'd0) return 32'd0;
      if (WE_RF && RW_RF == a) return DW_RF;
      return rf;
   endfunction

   task automatic check_state();
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
         chk("out_instr", out_instr, q[0].instr);
         chk("out_pc", out_pc, q[0].pc);
         chk("out_rs1_val", out_rs1_val, q[0].v1);
         chk("out_rs2_val", out_rs2_val, q[0].v2);
      end
      chk("stall_cnt", stall_cnt, stall_m);
   endtask

   // Apply the currently driven inputs for one clock edge, update the model, check.
   task automatic tick();
      ent_t e;
      bit   acc;
`ifdef OPF_STALL_CNT_EN
      bit   stalled;
`endif
      #1;
      chk("ra_rf", 32'(RA_RF), 32'(in_instr[19:15]));
      chk("rb_rf", 32'(RB_RF), 32'(in_instr[24:20]));
      acc     = in_valid && (q.size() < 2);
`ifdef OPF_STALL_CNT_EN
      stalled = in_valid && (q.size() >= 2);
`endif
      e.instr = in_instr;
      e.pc    = in_pc;
      e.a1    = in_instr[19:15];
      e.a2    = in_instr[24:20];
      e.v1    = opsel(e.a1, A_RF);
      e.v2    = opsel(e.a2, B_RF);
      @(posedge CLK);
      if (RES) begin
         q.delete();
         stall_m = '0;
      end else begin
`ifdef OPF_STALL_CNT_EN
         if (stalled && stall_m != '1) stall_m = stall_m + 1;
`endif
         if (flush) begin
            q.delete();
         end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (WE_RF && RW_RF != 5'd0) begin
               foreach (q[i]) begin
                  if (q[i].a1 == RW_RF) q[i].v1 = DW_RF;
                  if (q[i].a2 == RW_RF) q[i].v2 = DW_RF;
               end
            end
            if (acc) q.push_back(e);
         end
      end
      #1;
      check_state();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_instr"}, out_instr, 32'd0);
      chk({tag, "_out_pc"}, out_pc, 32'd0);
      chk({tag, "_out_rs1"}, out_rs1_val, 32'd0);
      chk({tag, "_out_rs2"}, out_rs2_val, 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
   endtask

   initial begin
      RES = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0;
      A_RF = 32'h0; B_RF = 32'h0; WE_RF = 1'b0; RW_RF = 5'd0; DW_RF = 32'h0;
      out_ready = 1'b0; stall_m = '0;
      #3;
      check_reset_outputs("reset");
      #9 RES = 1'b0;

      // Basic: add x0,x1,x2
      in_instr = 32'h00208033; A_RF = 32'd5; B_RF = 32'd7; in_pc = 32'h100;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_rs1", out_rs1_val, 32'd5);
      chk("basic_rs2", out_rs2_val, 32'd7);
      chk("basic_pc", out_pc, 32'h100);
      in_valid = 1'b0;
      tick();

      // Same-cycle bypass, then writeback to x0 (no bypass)
      in_instr = mk(5'd3, 5'd4); in_pc = 32'h110; A_RF = 32'h11; B_RF = 32'h22;
      WE_RF = 1'b1; RW_RF = 5'd3; DW_RF = 32'hDEADBEEF; in_valid = 1'b1;
      tick();
      chk("bypass_rs1", out_rs1_val, 32'hDEADBEEF);
      RW_RF = 5'd0; in_pc = 32'h114;
      tick();
      chk("bypass_x0_rs1", out_rs1_val, 32'h11);
      WE_RF = 1'b0; in_valid = 1'b0;
      tick();

      // Back-pressure and in-order drain
      out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(5'd1, 5'd2);
      in_pc = 32'h200; tick();
      in_pc = 32'h204; tick();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      in_pc = 32'h208; tick();
      chk("bp_head_pc", out_pc, 32'h200);
      out_ready = 1'b1;
      tick();
      chk("drain_pc1", out_pc, 32'h204);
      tick();
      chk("drain_pc2", out_pc, 32'h208);
      in_valid = 1'b0;
      tick();
      chk("drain_empty", 32'(out_valid), 32'd0);

      // Snoop of a held operand, then write to x0
      out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(5'd0, 5'd5); B_RF = 32'd1;
      in_pc = 32'h220; tick();
      in_valid = 1'b0; WE_RF = 1'b1; RW_RF = 5'd5; DW_RF = 32'h42;
      tick();
      chk("snoop_rs2", out_rs2_val, 32'h42);
      RW_RF = 5'd0; DW_RF = 32'h99;
      tick();
      chk("snoop_x0_rs2", out_rs2_val, 32'h42);
      WE_RF = 1'b0;

      // Flush with both entries held, then flush dropping a same-cycle accept
      flush = 1'b1; tick(); flush = 1'b0;
      in_valid = 1'b1; in_pc = 32'h300; tick();
      in_pc = 32'h304; tick();
      in_pc = 32'h308; flush = 1'b1; tick();
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_ready", 32'(in_ready), 32'd1);
      flush = 1'b0; in_pc = 32'h310; tick();
      in_pc = 32'h314; flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
      chk("flush_drop", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-stream
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h400; tick();
      in_pc = 32'h404; tick();
      #1 RES = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      q.delete(); stall_m = '0;
      tick();
      #1 RES = 1'b0;

      // Stall counter: two accepts, three stalled cycles
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_pc = 32'h500 + 32'(4 * i);
         tick();
      end
`ifdef OPF_STALL_CNT_EN
      chk("stall_cnt_3", stall_cnt, 32'd3);
`else
      chk("stall_cnt_off", stall_cnt, 32'd0);
`endif

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 20) == 0;
         in_instr  = $urandom;
         in_instr[19:15] = 5'($urandom % 8);
         in_instr[24:20] = 5'($urandom % 8);
         in_pc     = $urandom;
         A_RF      = $urandom;
         B_RF      = $urandom;
         WE_RF     = ($urandom % 2) != 0;
         RW_RF     = 5'($urandom % 8);
         DW_RF     = $urandom;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
